sample_strobe_rx: RTL and testbench
===================================

// Module: sample_strobe_rx
// PURPOSE
//  Receiving end of the divided sample-clock path. Takes an asynchronous slow sample clock
//  (e.g. the 50 kHz / 500 Hz sample clocks) plus the data word it qualifies into the clk domain.
//  Produces a one-cycle sample strobe, a buffered valid/ready sample stream, and a measured
//  sample period. Flags loss of the sample clock. Sits between the ADC/sample front end and
//  the FFT/measurement logic.
// PARAMETERS
//  DW       12      sample data width
//  PW       17      period counter/measurement width (clk cycles)
//  TIMEOUT  100000  clk cycles without a rising sclk_in edge before LOST
//  DEPTH    4       sample buffer depth, power of 2, >=2
// PORTS
//  clk          in   1     system clock (50 MHz)
//  rst_n        in   1     reset, asynchronous, active-low
//  sclk_in      in   1     asynchronous sample clock
//  din          in   DW    sample data, stable >=8 clk cycles after sclk_in rises
//  out_ready    in   1     downstream accepts out_data
//  out_valid    out  1     buffer non-empty
//  out_data     out  DW    head-of-buffer sample
//  strobe       out  1     one-cycle pulse per detected sclk_in rising edge
//  period       out  PW    clk cycles between the last two rising edges
//  period_valid out  1     period holds a valid measurement
//  lost         out  1     no edge for TIMEOUT cycles; cleared by the next edge
//  overflow     out  1     one-cycle pulse when a sample is dropped (buffer full)
// BEHAVIOUR
//  - Reset: all outputs 0, buffer empty, counter 0, state IDLE, sync flops 0.
//  - Sync: 2-FF synchroniser s1,s2, then s3. rise = s2 & ~s3.
//  - strobe is registered rise. It is high on the 4th clk edge after sclk_in rises (+/-1 cycle).
//  - On a strobe cycle: push din. out_valid is high the cycle after the push.
//  - Buffer: push on strobe, pop on out_valid & out_ready.
//    - Push while full with no pop: sample is dropped, overflow=1 for 1 cycle, contents unchanged.
//    - Push while full with a pop in the same cycle: push accepted, no overflow.
//    - Pop on empty: impossible, since out_valid=0.
//    - out_data must hold while out_valid & ~out_ready.
//  - Counter cnt: +1 per cycle, saturates at 2^PW-1. On a strobe cycle: cnt<=1.
//  - States (2-bit):
//    - IDLE: no edge seen. On strobe -> ARMED, cnt<=1.
//    - ARMED: one edge seen. On strobe -> LOCKED, period<=cnt, period_valid<=1.
//    - LOCKED: on strobe period<=cnt (period_valid stays 1).
//    - ARMED/LOCKED: cnt==TIMEOUT-1 with no strobe -> LOST: lost<=1, period_valid<=0,
//      period holds its last value.
//    - LOST: on strobe -> ARMED, lost<=0. The period is re-measured from this edge;
//      no period is reported across the gap.
//  - A strobe in the same cycle as cnt==TIMEOUT-1: the strobe wins, no LOST.
//  - Period of N clk cycles in steady state gives period==N exactly.
//  - Reset mid-operation: immediate return to reset values; buffered samples are discarded.
// STRUCTURE
//  - Package sample_pkg: state localparams IDLE=0, ARMED=1, LOCKED=2, LOST=3;
//    shared default DW/PW/TIMEOUT constants.
//  - One sub-module sample_fifo (#(DW,DEPTH)): synchronous FIFO with
//    push/pop/full/empty/dout and a count of ptr width+1.
//  - Top holds the synchroniser, edge detect, counter, FSM and overflow logic.
// TESTING
//  1. sclk_in 50 kHz (period 1000 clk), din=edge index -> strobe every 1000 cycles;
//     period_valid after 2nd edge; period==1000; out_data 0,1,2... in order.
//  2. out_ready=0, 6 edges, DEPTH=4 -> 4 samples held; overflow pulses on edges 5 and 6;
//     then out_ready=1 -> drains samples 0..3 only.
//  3. Buffer full and out_ready=1 in the strobe cycle -> no overflow; new sample is the last
//     entry.
//  4. Stop sclk_in after LOCKED -> lost=1 and period_valid=0 exactly TIMEOUT cycles after the
//     last strobe. Restart -> lost=0 at the 1st edge; period_valid=1 at the 2nd edge.
//  5. 500 Hz (period 100000) with TIMEOUT=100000 -> the edge coincides with the timeout;
//     no LOST, period==100000.
//  6. Assert rst_n low mid-stream with 3 samples buffered -> all outputs 0 asynchronously;
//     after release, state IDLE and the first edge gives ARMED with no period.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared constants for the sample-strobe receive path: FSM state codes and
// default widths/timeout used by sample_strobe_rx and its buffer.
package sample_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ARMED  = 2'd1;
  localparam state_t LOCKED = 2'd2;
  localparam state_t LOST   = 2'd3;

  localparam int unsigned DEF_DW      = 12;
  localparam int unsigned DEF_PW      = 17;
  localparam int unsigned DEF_TIMEOUT = 100000;
  localparam int unsigned DEF_DEPTH   = 4;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO buffering captured samples; a push while full is
// accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic                     full,
  output logic                     empty,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sample_strobe_rx.sv
// Brings an asynchronous sample clock into the clk domain: strobe per rising edge,
// buffered sample stream, period measurement and loss-of-clock detection.
module sample_strobe_rx
  import sample_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned PW      = DEF_PW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk_in,
  input  logic [DW-1:0] din,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          strobe,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          lost,
  output logic          overflow
);

  logic s1_q, s2_q, s3_q, rise, strobe_q, ovf_q;
  logic [PW-1:0] cnt_q, cnt_d, period_q, period_d;
  logic pv_q, pv_d, lost_q, lost_d;
  state_t state_q, state_d;
  logic full, empty, pop, timeout_hit;
  logic [$clog2(DEPTH):0] fill;

  assign rise = s2_q & ~s3_q;
  assign pop  = ~empty & out_ready;
  // An edge already in the synchroniser pipeline (rise) beats the timeout, so a
  // sample period equal to TIMEOUT still measures cleanly.
  assign timeout_hit = (cnt_q == PW'(TIMEOUT - 1)) & ~strobe_q & ~rise;

  sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (strobe_q),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .dout  (out_data),
    .count (fill)
  );

  always_comb begin
    if (rst_n) assert (empty == (fill == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      lost_q   <= 1'b0;
      state_q  <= IDLE;
    end else begin
      s1_q     <= sclk_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      strobe_q <= rise;
      ovf_q    <= strobe_q & full & ~pop;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      lost_q   <= lost_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (strobe_q) state_d = ARMED;
      ARMED:   if (strobe_q) state_d = LOCKED; else if (timeout_hit) state_d = LOST;
      LOCKED:  if (timeout_hit) state_d = LOST;
      LOST:    if (strobe_q) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    period_d = period_q;
    pv_d     = pv_q;
    lost_d   = lost_q;
    if (strobe_q) begin
      cnt_d = PW'(1);
    end else if (cnt_q == {PW{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (strobe_q) begin
      lost_d = 1'b0;
      if (state_q == ARMED || state_q == LOCKED) begin
        period_d = cnt_q;
        pv_d     = 1'b1;
      end
    end else if (timeout_hit && (state_q == ARMED || state_q == LOCKED)) begin
      lost_d = 1'b1;
      pv_d   = 1'b0;
    end
  end

  assign out_valid    = ~empty;
  assign strobe       = strobe_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign lost         = lost_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_sample_strobe_rx.sv
// Directed bench for sample_strobe_rx: a timestamp/queue model checked every cycle,
// plus literal expectations for each scenario.
module tb_sample_strobe_rx;

  localparam int DW      = 12;
  localparam int PW      = 17;
  localparam int TIMEOUT = 1200;
  localparam int DEPTH   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk_in = 1'b0;
  logic [DW-1:0] din = '0;
  logic          out_ready = 1'b0;
  logic          out_valid, strobe, period_valid, lost, overflow;
  logic [DW-1:0] out_data;
  logic [PW-1:0] period;

  sample_strobe_rx #(
    .DW      (DW),
    .PW      (PW),
    .TIMEOUT (TIMEOUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk_in      (sclk_in),
    .din          (din),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .strobe       (strobe),
    .period       (period),
    .period_valid (period_valid),
    .lost         (lost),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: strobe cycles are scheduled 3 cycles after the bench raises sclk_in;
  // everything else follows from strobe timestamps and a sample queue.
  int            sched[$];
  logic [DW-1:0] mq[$];
  int            m_last, m_edges, m_period;
  bit            m_lost, m_pv, m_ovf, s_now, pop_now;

  task automatic model_reset();
    sched.delete();
    mq.delete();
    m_last = 0; m_edges = 0; m_period = 0;
    m_lost = 0; m_pv = 0; m_ovf = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      s_now = (sched.size() > 0) && (sched[0] == cyc);
      chk("strobe", strobe, s_now);
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      chk("period", period, m_period);
      chk("period_valid", period_valid, m_pv);
      chk("lost", lost, m_lost);
      chk("overflow", overflow, m_ovf);
      #2;
      if (rst_n) begin
        pop_now = (mq.size() > 0) && out_ready;
        m_ovf = 0;
        if (pop_now) void'(mq.pop_front());
        if (s_now) begin
          if (mq.size() < DEPTH) mq.push_back(din);
          else m_ovf = 1;
          if (m_edges == 0 || m_lost) begin
            m_edges = 1;
            m_lost  = 0;
          end else begin
            m_period = cyc - m_last;
            m_pv     = 1;
            m_edges++;
          end
          m_last = cyc;
          void'(sched.pop_front());
        end else if (m_edges > 0 && !m_lost && cyc == m_last + TIMEOUT - 1 &&
                     !(sched.size() > 0 && sched[0] == cyc + 1)) begin
          m_lost = 1;
          m_pv   = 0;
        end
      end
    end
  end

  int            ovf_count = 0;
  int            last_strobe_seen = 0;
  int            lost_rise = 0;
  bit            lost_prev = 0;
  logic [DW-1:0] popped[$];

  always @(negedge clk) begin
    if (strobe) last_strobe_seen = cyc;
    if (lost && !lost_prev) lost_rise = cyc;
    lost_prev = lost;
    if (overflow) ovf_count++;
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) popped.push_back(out_data);
  end

  // One sclk_in period of per clk cycles, rising edge first; optional one-cycle
  // out_ready pulse aligned with the resulting strobe.
  task automatic sclk_edge(input int per, input logic [DW-1:0] d, input bit rdy_pulse);
    @(negedge clk);
    #1;
    sclk_in = 1'b1;
    din     = d;
    sched.push_back(cyc + 3);
    if (rdy_pulse) begin
      repeat (3) @(negedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      #1 out_ready = 1'b0;
      repeat (per / 2 - 4) @(negedge clk);
    end else begin
      repeat (per / 2) @(negedge clk);
    end
    #1 sclk_in = 1'b0;
    repeat (per - per / 2 - 1) @(negedge clk);
  endtask

  task automatic check_popped(input string name, input int first, input int n);
    chk({name, "_count"}, popped.size(), n);
    for (int i = 0; i < n && i < popped.size(); i++) chk(name, popped[i], first + i);
    popped.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_period_valid", period_valid, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // 1: steady 1000-cycle sample clock, data streamed straight through.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) sclk_edge(1000, DW'(i), 1'b0);
    chk("t1_period", period, 1000);
    chk("t1_period_valid", period_valid, 1);
    check_popped("t1_order", 0, 5);

    // 2: no consumer, six edges into a four-deep buffer.
    #1 out_ready = 1'b0;
    ovf_count = 0;
    for (int i = 0; i < 6; i++) sclk_edge(1000, DW'(i), 1'b0);
    chk("t2_overflow_pulses", ovf_count, 2);
    chk("t2_head", out_data, 0);
    #1 out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_popped("t2_drain", 0, 4);
    chk("t2_empty", out_valid, 0);

    // 3: push into a full buffer while it is being popped.
    #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sclk_edge(1000, DW'(10 + i), 1'b0);
    ovf_count = 0;
    sclk_edge(1000, DW'(14), 1'b1);
    chk("t3_no_overflow", ovf_count, 0);
    chk("t3_head", out_data, 11);
    #1 out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_popped("t3_drain", 10, 5);

    // 4: sample clock stops, then restarts.
    repeat (TIMEOUT + 20) @(negedge clk);
    chk("t4_lost", lost, 1);
    chk("t4_period_valid", period_valid, 0);
    chk("t4_period_held", period, 1000);
    chk("t4_lost_delay", lost_rise - last_strobe_seen, TIMEOUT);
    sclk_edge(1000, DW'(30), 1'b0);
    chk("t4_lost_cleared", lost, 0);
    chk("t4_no_period_yet", period_valid, 0);
    sclk_edge(1000, DW'(31), 1'b0);
    chk("t4_relocked", period_valid, 1);
    chk("t4_period", period, 1000);

    // 5: sample period equal to the timeout.
    for (int i = 0; i < 3; i++) sclk_edge(TIMEOUT, DW'(40 + i), 1'b0);
    chk("t5_period", period, TIMEOUT);
    chk("t5_not_lost", lost, 0);
    chk("t5_period_valid", period_valid, 1);

    // 6: asynchronous reset with samples buffered.
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) sclk_edge(1000, DW'(20 + i), 1'b0);
    chk("t6_period_gap", period, 1000);
    chk("t6_buffered", out_valid, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_strobe", strobe, 0);
    chk("t6_rst_period", period, 0);
    chk("t6_rst_period_valid", period_valid, 0);
    chk("t6_rst_lost", lost, 0);
    chk("t6_rst_overflow", overflow, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    sclk_edge(1000, DW'(50), 1'b0);
    chk("t6_armed_no_period", period_valid, 0);
    chk("t6_armed_period", period, 0);
    chk("t6_armed_valid", out_valid, 1);
    chk("t6_armed_data", out_data, 50);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
